// File: rtl/module_teclado_scan.sv
// 4x4 keypad scanner: rotates an active-low column drive, debounces the first
// key seen and emits a single strobe with its code per press.
//
// state        | meaning
// SCAN         | rotate columns, sample rows at the end of each column slot
// DEBOUNCE     | column held, latched row pattern must stay stable
// VALID        | one cycle: load tecla_o and raise en_tecla_o
// WAIT_RELEASE | column held until rows read all-high long enough
module module_teclado_scan #(
    parameter int SCAN_COUNT     = 10_000,
    parameter int BITS_SCAN      = 14,
    parameter int DEBOUNCE_COUNT = 200_000,
    parameter int BITS_DEB       = 18
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] tecla_o,
    output logic       en_tecla_o
);

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        VALID        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [BITS_SCAN-1:0] SCAN_LAST = BITS_SCAN'(SCAN_COUNT - 1);
    localparam logic [BITS_DEB-1:0]  DEB_LAST  = BITS_DEB'(DEBOUNCE_COUNT - 1);

    state_t               state;
    logic [3:0]           row_meta;
    logic [3:0]           rows;
    logic [BITS_SCAN-1:0] scan_cnt;
    logic [BITS_DEB-1:0]  deb_cnt;
    logic [1:0]           col_idx;
    logic [1:0]           row_idx;
    logic [3:0]           row_lat;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    col_drive = 4'b1110;
            2'd1:    col_drive = 4'b1101;
            2'd2:    col_drive = 4'b1011;
            default: col_drive = 4'b0111;
        endcase
    endfunction

    // Lowest-index low row wins when several rows are pulled down.
    function automatic logic [1:0] low_row(input logic [3:0] r);
        if (!r[0])      low_row = 2'd0;
        else if (!r[1]) low_row = 2'd1;
        else if (!r[2]) low_row = 2'd2;
        else            low_row = 2'd3;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
            4'hC: key_code = 4'hF;  4'hD: key_code = 4'h0;
            4'hE: key_code = 4'hE;  default: key_code = 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            row_meta <= 4'hF;
            rows     <= 4'hF;
        end else begin
            row_meta <= row_i;
            rows     <= row_meta;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= SCAN;
            scan_cnt   <= '0;
            deb_cnt    <= '0;
            col_idx    <= 2'd0;
            col_o      <= 4'b1110;
            row_idx    <= 2'd0;
            row_lat    <= 4'hF;
            tecla_o    <= 4'h0;
            en_tecla_o <= 1'b0;
        end else begin
            en_tecla_o <= 1'b0;
            case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (rows != 4'hF) begin
                            row_lat <= rows;
                            row_idx <= low_row(rows);
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col_o   <= col_drive(col_idx + 2'd1);
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rows != row_lat) begin
                        scan_cnt <= '0;
                        col_idx  <= col_idx + 2'd1;
                        col_o    <= col_drive(col_idx + 2'd1);
                        state    <= SCAN;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        state   <= VALID;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                VALID: begin
                    tecla_o    <= key_code(row_idx, col_idx);
                    en_tecla_o <= 1'b1;
                    deb_cnt    <= '0;
                    state      <= WAIT_RELEASE;
                end
                default: begin
                    // Any low row restarts the release window.
                    if (rows != 4'hF) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                        col_idx  <= col_idx + 2'd1;
                        col_o    <= col_drive(col_idx + 2'd1);
                        state    <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_teclado_scan.sv
// Directed bench for the keypad scanner with a small keypad model driving
// row_i and a scoreboard that checks every en_tecla_o strobe.
`timescale 1ns/1ps
module tb_module_teclado_scan;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] tecla_o;
    logic       en_tecla_o;

    logic [3:0][3:0] keys;   // keys[row][col] = 1 when pressed
    logic [3:0]      exp_q[$];
    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;
    int s0;

    module_teclado_scan #(
        .SCAN_COUNT(4), .BITS_SCAN(3), .DEBOUNCE_COUNT(8), .BITS_DEB(4)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .row_i(row_i),
        .col_o(col_o), .tecla_o(tecla_o), .en_tecla_o(en_tecla_o)
    );

    always #50 clk_i = ~clk_i;

    // A pressed key shorts its row to its column only while that column is driven low.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r][c] && !col_o[c]) row_i[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_col(input string name, input logic [3:0] c, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_i);
            if (col_o == c) seen = 1;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_col_change(input string name, input int budget);
        logic [3:0] c0 = col_o;
        bit moved = 0;
        for (int i = 0; i < budget && !moved; i++) begin
            @(negedge clk_i);
            if (col_o != c0) moved = 1;
        end
        check(name, {31'd0, moved}, 32'd1);
    endtask

    initial begin
        keys    = '0;
        rst_n_i = 1'b0;
        fork
            forever begin
                @(negedge clk_i);
                if (rst_n_i && en_tecla_o) begin
                    strobe_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_strobe: got=%0h required=no strobe", tecla_o);
                    end else begin
                        check("strobe_code", {28'd0, tecla_o}, {28'd0, exp_q.pop_front()});
                    end
                end
            end
            begin
                #2_000_000;
                $display("FAIL watchdog: got=timeout required=finish");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Asynchronous reset asserted mid-cycle after some scanning
        cycles(3);
        rst_n_i = 1'b1;
        cycles(10);
        @(posedge clk_i);
        #20 rst_n_i = 1'b0;
        #1;
        check("rst_col", {28'd0, col_o}, 32'b1110);
        check("rst_tecla", {28'd0, tecla_o}, 32'h0);
        check("rst_en", {31'd0, en_tecla_o}, 32'd0);
        cycles(2);
        rst_n_i = 1'b1;

        // Clean press of '5'
        s0 = strobe_cnt;
        keys[1][1] = 1'b1;
        exp_q.push_back(4'h5);
        wait_col("k5_lock_col", 4'b1101, 40);
        cycles(40);
        check("k5_held_col", {28'd0, col_o}, 32'b1101);
        check("k5_one_strobe", strobe_cnt - s0, 32'd1);
        keys[1][1] = 1'b0;
        cycles(8);
        check("k5_release_hold", {28'd0, col_o}, 32'b1101);
        wait_col("k5_release_adv", 4'b1011, 10);

        // Bouncing '9': 5 cycles low, 1 high, never stable long enough
        s0 = strobe_cnt;
        repeat (12) begin
            keys[2][2] = 1'b1;
            cycles(5);
            keys[2][2] = 1'b0;
            cycles(1);
        end
        cycles(20);
        check("k9_no_strobe", strobe_cnt - s0, 32'd0);
        wait_col_change("k9_back_to_scan", 8);

        // Long hold of 'E' then bouncy release
        s0 = strobe_cnt;
        keys[3][2] = 1'b1;
        exp_q.push_back(4'hE);
        wait_col("kE_lock_col", 4'b1011, 40);
        cycles(200);
        check("kE_held_col", {28'd0, col_o}, 32'b1011);
        repeat (3) begin
            keys[3][2] = 1'b0;
            cycles(3);
            keys[3][2] = 1'b1;
            cycles(2);
        end
        keys[3][2] = 1'b0;
        cycles(4);
        check("kE_bounce_hold", {28'd0, col_o}, 32'b1011);
        check("kE_one_strobe", strobe_cnt - s0, 32'd1);
        wait_col("kE_release_adv", 4'b0111, 20);
        keys[1][1] = 1'b1;
        exp_q.push_back(4'h5);
        cycles(40);
        check("new_press_strobe", strobe_cnt - s0, 32'd2);
        keys[1][1] = 1'b0;
        cycles(20);

        // Rows 0 and 3 of column 0 together, plus a column-2 key meanwhile
        s0 = strobe_cnt;
        keys[0][0] = 1'b1;
        keys[3][0] = 1'b1;
        exp_q.push_back(4'h1);
        wait_col("multi_lock_col", 4'b1110, 40);
        cycles(20);
        keys[1][2] = 1'b1;
        cycles(30);
        check("multi_held_col", {28'd0, col_o}, 32'b1110);
        check("multi_one_strobe", strobe_cnt - s0, 32'd1);
        keys[1][2] = 1'b0;
        cycles(2);
        keys[0][0] = 1'b0;
        keys[3][0] = 1'b0;
        cycles(50);
        check("multi_other_col_ignored", strobe_cnt - s0, 32'd1);

        // Reset pulse while '7' is being debounced
        s0 = strobe_cnt;
        wait_col("k7_sync_col1", 4'b1101, 20);
        keys[2][0] = 1'b1;
        wait_col("k7_col0", 4'b1110, 20);
        cycles(7);
        rst_n_i = 1'b0;
        #1;
        check("k7_rst_col", {28'd0, col_o}, 32'b1110);
        check("k7_rst_en", {31'd0, en_tecla_o}, 32'd0);
        keys[2][0] = 1'b0;
        cycles(2);
        rst_n_i = 1'b1;
        cycles(30);
        check("k7_no_strobe", strobe_cnt - s0, 32'd0);
        check("k7_tecla_cleared", {28'd0, tecla_o}, 32'h0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/module_teclado_scan.md
MODULE_TECLADO_SCAN -- requirements
Module: module_teclado_scan

Interface
REQ-001 The block SHALL have parameter SCAN_COUNT, default 10_000, giving the clock cycles each column stays driven (1 ms at 10 MHz).
REQ-002 The block SHALL have parameter BITS_SCAN, default 14, giving the scan counter width.
REQ-003 The block SHALL have parameter DEBOUNCE_COUNT, default 200_000, giving the stable cycles required for press and release (20 ms at 10 MHz).
REQ-004 The block SHALL have parameter BITS_DEB, default 18, giving the debounce counter width.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the 10 MHz system clock; the only clock.
REQ-006 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port row_i, input, 4 bits: keypad rows, active-low, externally pulled up, asynchronous to clk_i.
REQ-008 The block SHALL have port col_o, output, 4 bits: keypad column drive, active-low, exactly one bit low at any time.
REQ-009 The block SHALL have port tecla_o, output, 4 bits: code of the last accepted key, held until the next accepted key.
REQ-010 The block SHALL have port en_tecla_o, output, 1 bit: single-cycle strobe, high in the cycle tecla_o takes a new code.

Function
REQ-011 row_i SHALL pass through a 2-flop synchronizer before any use; "rows" below means the synchronized value.
REQ-012 The key map SHALL be (row r, column c → code): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: F(*),0,E(#),D.
REQ-013 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, VALID, WAIT_RELEASE.
REQ-014 In SCAN, the driven column SHALL rotate 1110→1101→1011→0111→1110, advancing one step when the scan counter reaches SCAN_COUNT-1; the counter then returns to 0.
REQ-015 In SCAN, rows SHALL be sampled in the cycle the scan counter equals SCAN_COUNT-1. If rows ≠ 4'hF, the FSM SHALL latch the column and lowest-index low row, hold col_o, clear the debounce counter and enter DEBOUNCE.
REQ-016 In DEBOUNCE, if rows equal the latched pattern for DEBOUNCE_COUNT consecutive cycles, the FSM SHALL enter VALID; any deviation SHALL return it to SCAN, advancing to the next column.
REQ-017 VALID SHALL last one cycle, load tecla_o with the mapped code and assert en_tecla_o, then enter WAIT_RELEASE.
REQ-018 In WAIT_RELEASE, col_o SHALL stay held; the FSM SHALL return to SCAN (next column) only after rows = 4'hF for DEBOUNCE_COUNT consecutive cycles; any low row SHALL restart the count.
REQ-019 A held key SHALL produce exactly one strobe regardless of hold time; there is no auto-repeat.
REQ-020 If several rows are low in the latched column, the lowest row index SHALL win and the full row pattern SHALL be debounced as-is.
REQ-021 Keys in other columns pressed while in DEBOUNCE, VALID or WAIT_RELEASE SHALL be ignored.
REQ-022 Counters SHALL saturate-free wrap only as described; no counter SHALL exceed its terminal value.

Reset
REQ-023 While rst_n_i = 0, the block SHALL force: state SCAN, col_o = 4'b1110, tecla_o = 4'h0, en_tecla_o = 0, all counters 0, synchronizer flops 4'hF.
REQ-024 Assertion of rst_n_i mid-operation (any state) SHALL take effect immediately and suppress any pending strobe; scanning SHALL resume from column 0 after release.

Verification (SCAN_COUNT=4, DEBOUNCE_COUNT=8)
REQ-025 The bench SHALL check reset: assert rst_n_i=0 asynchronously mid-cycle → col_o=1110, tecla_o=0, en_tecla_o=0 immediately.
REQ-026 The bench SHALL check a clean press: hold key '5' (col1,row1) steady → one en_tecla_o pulse with tecla_o=5, col_o held at 1101 until release plus 8 clean cycles.
REQ-027 The bench SHALL check bounce rejection: toggle key '9' low for 5 cycles, high for 1, repeatedly → no strobe, FSM returns to SCAN.
REQ-028 The bench SHALL check long hold and release: hold 'E' (#) for 200 cycles, then release with 3 bounces → exactly one strobe with code E; the next strobe appears only for a new press after 8 clean release cycles.
REQ-029 The bench SHALL check a multi-key press: press rows 0 and 3 of col0 together → tecla_o=1; a key pressed meanwhile in col2 produces no strobe.
REQ-030 The bench SHALL check reset during debounce: rst_n_i pulsed low during DEBOUNCE of '7' → no strobe, col_o=1110, tecla_o=0.
